// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types for the FPU issue stage: fpnew-style operation fields and the
// request payload that travels through the request FIFO.
package fpu_issue_ctrl_pkg;

  localparam int unsigned RND_W  = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FMT_W  = 3;
  localparam int unsigned IFMT_W = 2;

  typedef enum logic [RND_W-1:0] {
    RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4, ROD = 3'd5, DYN = 3'd7
  } roundmode_e;

  typedef enum logic [OP_W-1:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [FMT_W-1:0] {
    FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [IFMT_W-1:0] {INT8, INT16, INT32, INT64} int_format_e;

  // Operation fields of one request; operands are carried alongside.
  typedef struct packed {
    roundmode_e  rnd_mode;
    operation_e  op;
    logic        op_mod;
    fp_format_e  src_fmt;
    fp_format_e  dst_fmt;
    int_format_e int_fmt;
    logic        vectorial_op;
  } fpu_req_t;

  localparam int unsigned FPU_REQ_W = $bits(fpu_req_t);

endpackage

// File: rtl/fpu_req_fifo.sv
// Synchronous FIFO with clear; pointers carry one extra wrap bit so full and
// empty are told apart without a separate count.
module fpu_req_fifo #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [DataW-1:0] mem_q [Depth];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue stage in front of the FPU: buffers requests, tags them with a rolling
// tag, throttles on in-flight tags and retires them from the result handshake.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_OPERANDS = 3,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned TAG_W        = 3,
  parameter int unsigned MAX_OUT      = 8,
  localparam int unsigned CNT_W       = $clog2(MAX_OUT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NUM_OPERANDS*WIDTH-1:0] req_operands,
  input  logic [RND_W-1:0]              req_rnd_mode,
  input  logic [OP_W-1:0]               req_op,
  input  logic                          req_op_mod,
  input  logic [FMT_W-1:0]              req_src_fmt,
  input  logic [FMT_W-1:0]              req_dst_fmt,
  input  logic [IFMT_W-1:0]             req_int_fmt,
  input  logic                          req_vectorial_op,
  output logic [NUM_OPERANDS*WIDTH-1:0] fpu_operands,
  output logic [RND_W-1:0]              fpu_rnd_mode,
  output logic [OP_W-1:0]               fpu_op,
  output logic                          fpu_op_mod,
  output logic [FMT_W-1:0]              fpu_src_fmt,
  output logic [FMT_W-1:0]              fpu_dst_fmt,
  output logic [IFMT_W-1:0]             fpu_int_fmt,
  output logic                          fpu_vectorial_op,
  output logic [TAG_W-1:0]              fpu_tag,
  output logic                          fpu_in_valid,
  input  logic                          fpu_in_ready,
  output logic                          fpu_flush,
  input  logic [TAG_W-1:0]              fpu_tag_o,
  input  logic                          fpu_out_valid,
  input  logic                          fpu_out_ready,
  input  logic                          flush,
  output logic                          busy,
  output logic [CNT_W-1:0]              outstanding,
  output logic                          tag_err
);

  localparam int unsigned OpsW     = NUM_OPERANDS * WIDTH;
  localparam int unsigned EntryW   = OpsW + FPU_REQ_W;
  localparam int unsigned NumTags  = 2 ** TAG_W;
  localparam logic [CNT_W-1:0] MaxOutCnt = CNT_W'(MAX_OUT);

  fpu_req_t          req_fields, head_fields;
  logic [OpsW-1:0]   head_operands;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              push, issue, retire, retire_ignore, retire_hit, retire_miss, eligible;

  logic [TAG_W-1:0]   next_tag_q, next_tag_d;
  logic [NumTags-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               fpu_flush_q, tag_err_q;

  always_comb begin
    req_fields.rnd_mode     = roundmode_e'(req_rnd_mode);
    req_fields.op           = operation_e'(req_op);
    req_fields.op_mod       = req_op_mod;
    req_fields.src_fmt      = fp_format_e'(req_src_fmt);
    req_fields.dst_fmt      = fp_format_e'(req_dst_fmt);
    req_fields.int_fmt      = int_format_e'(req_int_fmt);
    req_fields.vectorial_op = req_vectorial_op;
  end

  assign fifo_wdata                    = {req_operands, req_fields};
  assign {head_operands, head_fields}  = fifo_rdata;

  // req_ready ignores a same-cycle pop; a push during flush is dropped.
  assign req_ready = rst & ~fifo_full;
  assign push      = req_valid & req_ready & ~flush;

  assign eligible     = ~fifo_empty & (count_q < MaxOutCnt) & ~inflight_q[next_tag_q];
  assign fpu_in_valid = rst & ~flush & eligible;
  assign issue        = fpu_in_valid & fpu_in_ready;

  // Results still draining from a flushed FPU are dropped silently.
  assign retire        = fpu_out_valid & fpu_out_ready;
  assign retire_ignore = flush | fpu_flush_q;
  assign retire_hit    = retire & ~retire_ignore & inflight_q[fpu_tag_o];
  assign retire_miss   = retire & ~retire_ignore & ~inflight_q[fpu_tag_o];

  fpu_req_fifo #(
    .DataW(EntryW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .push (push),
    .pop  (issue),
    .wdata(fifo_wdata),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    next_tag_d = next_tag_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    if (issue) begin
      inflight_d[next_tag_q] = 1'b1;
      next_tag_d             = next_tag_q + TAG_W'(1);
    end
    if (retire_hit) inflight_d[fpu_tag_o] = 1'b0;
    if (issue && !retire_hit) begin
      count_d = count_q + CNT_W'(1);
    end else if (!issue && retire_hit) begin
      count_d = count_q - CNT_W'(1);
    end
    if (flush) begin
      inflight_d = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      next_tag_q  <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      fpu_flush_q <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      next_tag_q  <= next_tag_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      fpu_flush_q <= flush;
      tag_err_q   <= retire_miss;
    end
  end

  always_comb begin
    fpu_operands     = '0;
    fpu_rnd_mode     = '0;
    fpu_op           = '0;
    fpu_op_mod       = 1'b0;
    fpu_src_fmt      = '0;
    fpu_dst_fmt      = '0;
    fpu_int_fmt      = '0;
    fpu_vectorial_op = 1'b0;
    if (fpu_in_valid) begin
      fpu_operands     = head_operands;
      fpu_rnd_mode     = head_fields.rnd_mode;
      fpu_op           = head_fields.op;
      fpu_op_mod       = head_fields.op_mod;
      fpu_src_fmt      = head_fields.src_fmt;
      fpu_dst_fmt      = head_fields.dst_fmt;
      fpu_int_fmt      = head_fields.int_fmt;
      fpu_vectorial_op = head_fields.vectorial_op;
    end
  end

  assign fpu_tag     = next_tag_q;
  assign fpu_flush   = fpu_flush_q;
  assign tag_err     = tag_err_q;
  assign outstanding = count_q;
  assign busy        = ~fifo_empty | (count_q != '0);

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Request-buffering issue stage directly upstream of the fpnew FPU wrapper. Accepts operation requests from a producer, queues them in a small FIFO, and attaches a unique rolling tag to each one. It issues requests to the FPU under the fpnew valid/ready handshake and tracks in-flight tags until the FPU's result handshake retires them. A single `flush` input cancels all queued and in-flight work.

## Interface
- `NUM_OPERANDS`, 3, operands per request
- `WIDTH`, 16, operand/result width in bits
- `DEPTH`, 4, request FIFO entries (power of two, ≥2)
- `TAG_W`, 3, tag width; tags wrap modulo 2^TAG_W
- `MAX_OUT`, 8, max in-flight operations (1..2^TAG_W)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous reset, active-low
- `req_valid` in 1: producer request valid
- `req_ready` out 1: request accepted when `req_valid && req_ready`
- `req_operands` in NUM_OPERANDS×WIDTH: operands
- `req_rnd_mode`, `req_op`, `req_op_mod`, `req_src_fmt`, `req_dst_fmt`, `req_int_fmt`, `req_vectorial_op` in (fpnew_pkg types): operation fields
- `fpu_operands` … `fpu_vectorial_op` out: FIFO-head payload to the FPU
- `fpu_tag` out TAG_W: tag of issued request
- `fpu_in_valid` out 1 / `fpu_in_ready` in 1: FPU input handshake
- `fpu_flush` out 1: flush pulse to the FPU
- `fpu_tag_o` in TAG_W, `fpu_out_valid` in 1, `fpu_out_ready` in 1: monitored FPU result handshake
- `flush` in 1: cancel everything
- `busy` out 1: FIFO non-empty or in-flight count ≠ 0
- `outstanding` out $clog2(MAX_OUT+1): in-flight count
- `tag_err` out 1: one-cycle pulse on retirement of a tag that is not in flight

## Operation
- Push: `req_valid && req_ready`. `req_ready = !full`; it does not depend on a same-cycle pop, so when full, no push occurs even if the FPU pops that cycle.
- No bypass: a request reaches `fpu_in_valid` at the earliest one cycle after it is accepted.
- Issue eligibility: `!empty && outstanding < MAX_OUT && !inflight[next_tag]`. `fpu_in_valid` equals eligibility. The payload and `fpu_tag` stay stable while `fpu_in_valid && !fpu_in_ready`.
- Eligibility can only drop through flush, because retirement never reduces it.
- Issue (`fpu_in_valid && fpu_in_ready`): pop the FIFO, set `inflight[next_tag]`, then `next_tag++` with wrap.
- Retire (`fpu_out_valid && fpu_out_ready`):
  - If `inflight[fpu_tag_o]` is set: clear the bit and decrement the count.
  - Otherwise: pulse `tag_err` and change no state.
- Same-cycle issue and retire: both bitmap updates apply and the count is unchanged. Eligibility uses the registered bitmap, so a tag retired this cycle becomes reissuable next cycle.
- Flush (`flush=1`):
  - Next cycle: FIFO empty, `inflight` all zero, `outstanding=0`.
  - `next_tag` is preserved.
  - `fpu_flush=1` for exactly that one cycle (registered).
  - A push in the flush cycle is discarded.
  - Retirements in the flush cycle and the following cycle are ignored without `tag_err`.
  - `fpu_in_valid=0` during the flush cycle.
- Reset, including mid-operation:
  - All state is cleared and `next_tag=0`.
  - Outputs: `req_ready=0` while `rst=0` and 1 afterwards; `fpu_in_valid=0`, `fpu_flush=0`, `busy=0`, `outstanding=0`, `tag_err=0`.
  - Payload outputs are 0.

## Timing
- Accept-to-issue latency: 1 cycle minimum.
- Sustained throughput: 1 issue per cycle when the FPU is ready and `MAX_OUT` is not reached.
- `busy` and `outstanding` are registered and reflect state after the last edge.
- `tag_err` is registered and asserts the cycle after the offending retirement.
- FIFO pointers are `$clog2(DEPTH)+1` bits and wrap naturally. Full: MSBs differ and LSBs are equal.

## Structure
- Constants and the request payload struct (`fpu_req_t`) go in the shared TB package next to the fpnew types.
- Sub-module `fpu_req_fifo`: a parameterised sync FIFO with push, pop, full, empty and clear.
- The tag counter, in-flight bitmap and count live in the top level.

## Test plan
- Reset, then push 1 request (FADD) with `fpu_in_ready=1`: `fpu_in_valid` rises the cycle after acceptance, `fpu_tag=0`, `outstanding=1`, `busy=1`.
- `fpu_in_ready=0`, push 4 requests with DEPTH=4: `req_ready=0` after the 4th. Payload and tag are held stable. Release ready: 4 issues on consecutive cycles with tags 0,1,2,3.
- MAX_OUT=2, no retirements, 3 requests: only tags 0 and 1 issue. Retire tag 0: the 3rd issues next cycle with tag 2.
- 10 issue/retire pairs with TAG_W=3: tags run 0..7, then 0,1. `outstanding` never exceeds 1.
- 2 in flight plus 2 queued, assert `flush`: next cycle `fpu_flush=1`, FIFO empty, `outstanding=0`, `busy=0`. Late retire of tag 0 gives no `tag_err`.
- Retire tag 5 while nothing is in flight: `tag_err` pulses for 1 cycle and `outstanding` stays 0.
